// File: rtl/wb_stage_buf.sv
// ---------------------------------------------------------------------------
// wb_stage_buf
//
// Registered writeback stage. Takes one retiring op per cycle from execute,
// picks its writeback value, and queues completed register writes in a small
// FIFO that drains into the register-file write port. Loads are held in a
// pending slot until the load unit returns data. A lookup port returns the
// youngest queued (or pending) value for a register so that younger
// instructions can forward or stall. Also provides the ALU operand-2 select.
//
// Ports
//   clk_in, rst_n_in           clock / asynchronous active-low reset
//   ex_valid_in, ex_ready_out  execute -> writeback handshake
//   rd_addr_in, rd_wr_en_in    destination register and write enable of the op
//   wb_mux_sel_in              writeback source select (000 ALU, 001 load,
//                              010 imm, 011 iadder, 101 pc+4, others -> 0)
//   alu_src_in                 operand-2 select (1: rs2, 0: imm)
//   imm_in, rs2_in, alu_result_in, iadder_out_in, pc_plus_4_in  source values
//   lu_valid_in, lu_output_in  load-unit return (one pulse per load)
//   alu_2_src_mux_out          combinational operand-2 mux
//   wb_valid_out, wb_ready_in  FIFO head handshake to the register file
//   wb_rd_out, wb_data_out     FIFO head contents (zero when empty)
//   fwd_addr_in                forwarding lookup register
//   fwd_hit_out, fwd_data_out  lookup result (data 0 while a load is in flight)
// ---------------------------------------------------------------------------
module wb_stage_buf #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               ex_valid_in,
    output logic               ex_ready_out,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic               rd_wr_en_in,
    input  logic [2:0]         wb_mux_sel_in,
    input  logic               alu_src_in,
    input  logic [XLEN-1:0]    imm_in,
    input  logic [XLEN-1:0]    rs2_in,
    input  logic [XLEN-1:0]    alu_result_in,
    input  logic [XLEN-1:0]    iadder_out_in,
    input  logic [XLEN-1:0]    pc_plus_4_in,
    input  logic               lu_valid_in,
    input  logic [XLEN-1:0]    lu_output_in,
    output logic [XLEN-1:0]    alu_2_src_mux_out,
    output logic               wb_valid_out,
    input  logic               wb_ready_in,
    output logic [RADDR_W-1:0] wb_rd_out,
    output logic [XLEN-1:0]    wb_data_out,
    input  logic [RADDR_W-1:0] fwd_addr_in,
    output logic               fwd_hit_out,
    output logic [XLEN-1:0]    fwd_data_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] SEL_ALU    = 3'b000;
    localparam logic [2:0] SEL_LOAD   = 3'b001;
    localparam logic [2:0] SEL_IMM    = 3'b010;
    localparam logic [2:0] SEL_IADDER = 3'b011;
    localparam logic [2:0] SEL_PC4    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LD = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // Control state
    state_e               state_q, state_d;
    logic [RADDR_W-1:0]   pend_rd_q, pend_rd_d;
    logic                 pend_wr_q, pend_wr_d;
    logic [XLEN-1:0]      hold_data_q, hold_data_d;

    // FIFO state
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [RADDR_W-1:0]   mem_rd_q   [DEPTH];
    logic [RADDR_W-1:0]   mem_rd_d   [DEPTH];
    logic [XLEN-1:0]      mem_data_q [DEPTH];
    logic [XLEN-1:0]      mem_data_d [DEPTH];

    // Internal strobes
    logic                 fifo_full;
    logic                 pop;
    logic                 accept;
    logic                 op_writes;
    logic [XLEN-1:0]      sel_value;
    logic                 push;
    logic [RADDR_W-1:0]   push_rd;
    logic [XLEN-1:0]      push_data;

    // -----------------------------------------------------------------------
    // Datapath selects and handshakes
    // -----------------------------------------------------------------------
    assign alu_2_src_mux_out = alu_src_in ? rs2_in : imm_in;

    assign fifo_full    = (count_q == CNT_W'(DEPTH));
    assign wb_valid_out = (count_q != '0);
    assign pop          = wb_valid_out && wb_ready_in;

    // Reset is folded in so the stage never advertises readiness while the
    // rest of the pipeline is still being cleared.
    assign ex_ready_out = rst_n_in && (state_q == ST_IDLE) && !fifo_full;
    assign accept       = ex_valid_in && ex_ready_out;

    // x0 is hard-wired zero, so writes to it are dropped here rather than
    // occupying a FIFO slot.
    assign op_writes    = rd_wr_en_in && (rd_addr_in != '0);

    // Head is gated so an empty FIFO presents zeros instead of stale entries.
    assign wb_rd_out    = wb_valid_out ? mem_rd_q[rd_ptr_q]   : '0;
    assign wb_data_out  = wb_valid_out ? mem_data_q[rd_ptr_q] : '0;

    always_comb begin
        case (wb_mux_sel_in)
            SEL_ALU:    sel_value = alu_result_in;
            SEL_LOAD:   sel_value = lu_output_in;
            SEL_IMM:    sel_value = imm_in;
            SEL_IADDER: sel_value = iadder_out_in;
            SEL_PC4:    sel_value = pc_plus_4_in;
            default:    sel_value = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM: decides what (if anything) is pushed this cycle
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        pend_wr_d   = pend_wr_q;
        hold_data_d = hold_data_q;
        push        = 1'b0;
        push_rd     = '0;
        push_data   = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (wb_mux_sel_in == SEL_LOAD) begin
                        if (lu_valid_in) begin
                            // Data arrived with the op: no need to park it.
                            push      = op_writes;
                            push_rd   = rd_addr_in;
                            push_data = lu_output_in;
                        end else begin
                            state_d   = ST_WAIT_LD;
                            pend_rd_d = rd_addr_in;
                            pend_wr_d = op_writes;
                        end
                    end else begin
                        push      = op_writes;
                        push_rd   = rd_addr_in;
                        push_data = sel_value;
                    end
                end
            end

            ST_WAIT_LD: begin
                if (lu_valid_in) begin
                    if (!pend_wr_q) begin
                        // Load to x0 or without write enable: just retire it.
                        state_d = ST_IDLE;
                    end else if (!fifo_full) begin
                        push      = 1'b1;
                        push_rd   = pend_rd_q;
                        push_data = lu_output_in;
                        state_d   = ST_IDLE;
                    end else begin
                        // The load unit does not re-send, so the data must be
                        // captured even when there is no slot for it yet.
                        hold_data_d = lu_output_in;
                        state_d     = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // A pop in the same cycle frees the slot this push uses.
                if (!fifo_full || pop) begin
                    push      = 1'b1;
                    push_rd   = pend_rd_q;
                    push_data = hold_data_q;
                    state_d   = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO next state
    // -----------------------------------------------------------------------
    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push) begin
            mem_rd_d[wr_ptr_q]   = push_rd;
            mem_data_d[wr_ptr_q] = push_data;
            // DEPTH is a power of two, so the natural overflow wraps the pointer.
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Forwarding lookup: youngest match wins
    // -----------------------------------------------------------------------
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        fwd_hit_out  = 1'b0;
        fwd_data_out = '0;

        if (fwd_addr_in != '0) begin
            // Walk oldest to youngest so a later match overrides an earlier one.
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (mem_rd_q[idx] == fwd_addr_in)) begin
                    fwd_hit_out  = 1'b1;
                    fwd_data_out = mem_data_q[idx];
                end
            end
            // The pending load is younger than anything already queued. While
            // its data is outstanding the hit carries 0 and the consumer stalls.
            if ((state_q != ST_IDLE) && pend_wr_q && (pend_rd_q == fwd_addr_in)) begin
                fwd_hit_out  = 1'b1;
                fwd_data_out = (state_q == ST_HOLD) ? hold_data_q : '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            pend_rd_q   <= '0;
            pend_wr_q   <= 1'b0;
            hold_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            hold_data_q <= hold_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only observable
    // through count_q, which is reset, so stale contents are never visible.
    always_ff @(posedge clk_in) begin
        mem_rd_q   <= mem_rd_d;
        mem_data_q <= mem_data_d;
    end

endmodule
